// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx. First-word-fall-through read side with optional
// LF -> CR,LF expansion; sticky flag for tx_ready pulses arriving with no data.
module uart_tx_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter bit          LF_TO_CRLF = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [7:0]               wr_data,
  output logic                     tx_req,
  input  logic                     tx_ready,
  output logic [7:0]               tx_data,
  output logic [$clog2(DEPTH):0]   fill_level,
  input  logic                     err_clr,
  output logic                     proto_err
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  typedef enum logic {
    PASS,
    CR_SENT
  } out_state_e;

  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] fill_q, fill_d;
  out_state_e  state_q, state_d;
  logic        err_q, err_d;

  logic        full, empty, head_lf, wr_en, pop;
  logic [7:0]  head;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign head_lf = LF_TO_CRLF && (head == 8'h0A);

  assign wr_ready   = !full;
  assign tx_req     = !empty;
  assign fill_level = fill_q;
  assign proto_err  = err_q;

  // Storage and pointer update: write on accept, pop when the head byte is fully sent.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en    = wr_valid && !full;
    // An LF head in PASS only sends the inserted CR; the entry leaves in CR_SENT.
    pop      = tx_ready && !empty && ((state_q == CR_SENT) || !head_lf);
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end
    fill_d = wr_ptr_d - rd_ptr_d;
    err_d  = (tx_ready && empty) || (err_q && !err_clr);
  end

  // Output FSM next state and presented byte.
  always_comb begin
    state_d = state_q;
    tx_data = 8'h00;
    if (!empty) begin
      if (state_q == PASS && head_lf) begin
        tx_data = 8'h0D;
        if (tx_ready) state_d = CR_SENT;
      end else begin
        tx_data = head;
        if (tx_ready) state_d = PASS;
      end
    end
  end

  // State registers; reset discards all queued contents.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      state_q  <= PASS;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      state_q  <= state_d;
      err_q    <= err_d;
    end
  end

  // Byte storage; contents are meaningless while the pointers say empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo (DEPTH=16, LF_TO_CRLF=1).
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_ = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       tx_req;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic [4:0] fill_level;
  logic       err_clr = 1'b0;
  logic       proto_err;

  typedef struct {
    logic [7:0] b;
    bit         pops;
  } exp_t;

  exp_t exp_q[$];
  int   fill_mdl = 0;
  bit   err_mdl  = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  uart_tx_fifo #(
    .DEPTH      (DEPTH),
    .LF_TO_CRLF (1'b1)
  ) u_dut (
    .clk        (clk),
    .reset_     (reset_),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .tx_req     (tx_req),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .fill_level (fill_level),
    .err_clr    (err_clr),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("fill_level", fill_level, fill_mdl);
    chk("wr_ready", wr_ready, (fill_mdl < DEPTH));
    chk("tx_req", tx_req, (exp_q.size() != 0));
    chk("proto_err", proto_err, err_mdl);
    if (exp_q.size() != 0) chk("tx_data_head", tx_data, exp_q[0].b);
    else                   chk("tx_data_idle", tx_data, 8'h00);
  endtask

  // One clock: drive at negedge, update model, check after the posedge.
  task automatic step(input logic wv, input logic [7:0] wd, input logic tr, input logic ec);
    exp_t e;
    bit   stray;
    bit   acc;
    acc   = wv && (fill_mdl < DEPTH);
    stray = 0;
    wr_valid = wv; wr_data = wd; tx_ready = tr; err_clr = ec;
    if (tr) begin
      if (exp_q.size() == 0) stray = 1;
      else begin
        e = exp_q.pop_front();
        chk("tx_data_pop", tx_data, e.b);
        if (e.pops) fill_mdl--;
      end
    end
    if (acc) begin
      if (wd == 8'h0A) begin
        exp_q.push_back('{b: 8'h0D, pops: 1'b0});
        exp_q.push_back('{b: 8'h0A, pops: 1'b1});
      end else begin
        exp_q.push_back('{b: wd, pops: 1'b1});
      end
      fill_mdl++;
    end
    err_mdl = stray || (err_mdl && !ec);
    @(negedge clk);
    wr_valid = 1'b0; tx_ready = 1'b0; err_clr = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    wr_valid = 1'b0; tx_ready = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    reset_ = 1'b1;
    exp_q.delete();
    fill_mdl = 0;
    err_mdl  = 0;
    check_outputs();
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // 1: single byte round trip
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // 2: fill to DEPTH, blocked 17th byte, drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // 3: LF expansion 0x48,0x0D,0x0A,0x49
    step(1'b1, 8'h48, 1'b0, 1'b0);
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    step(1'b1, 8'h49, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // 4: hold fill at 5 with simultaneous write+pop across pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // 5: stray tx_ready, set-wins, clear; write alongside stray pulse
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // 6: reset while in CR_SENT, then LF must yield CR first
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    chk("post_reset_cr", tx_data, 8'h0D);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic, occasional stray pulses and clears
    for (int i = 0; i < 300; i++) begin
      logic wv, tr, ec;
      wv = ($urandom_range(0, 2) != 0);
      tr = (exp_q.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      ec = ($urandom_range(0, 7) == 0);
      step(wv, ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom_range(0, 255)), tr, ec);
    end
    while (exp_q.size() != 0 && n_cmp < 100000) step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
